lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/lsu_mem_ctrl_if.sv | 29 ++
 rtl/lsu_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Core-request and memory-port signal bundle for lsu_mem_ctrl.
// slave is the controller's view; master is the core/memory environment's view.
interface lsu_mem_ctrl_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       rdata;
  logic              fault;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, op, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, rdata, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport master (
    output req_valid, op, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, rdata, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: byte/half/word access over a 32-bit word port (MISALIGN_SPLIT_EN enables word-crossing splits).
// Latency: accept N, mem_req N+1, resp_valid N+3 for one beat (+2 per extra beat); faults respond at N+1.
// Backpressure: one request in flight, req_ready only in IDLE; memory stalls via mem_gnt/mem_rvalid.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  lsu_mem_ctrl_if.slave      bus
);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        load_q;
  logic        sext_q;
  logic        cross_q;
  logic [2:0]  mask_hi_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata0_q;

  logic [2:0]  d_size;
  logic        d_load;
  logic        d_sext;
  logic        d_legal;
  logic        d_misal;
  logic        d_cross;
  logic [1:0]  d_off;
  logic [3:0]  d_base;
  logic [6:0]  d_mask;

  always_comb begin
    d_size  = 3'd0;
    d_load  = 1'b0;
    d_sext  = 1'b0;
    d_legal = 1'b1;
    case (bus.op)
      6'd0:    begin d_size = 3'd1; d_load = 1'b1; d_sext = 1'b1; end
      6'd1:    begin d_size = 3'd2; d_load = 1'b1; d_sext = 1'b1; end
      6'd2:    begin d_size = 3'd4; d_load = 1'b1; end
      6'd3:    begin d_size = 3'd1; d_load = 1'b1; end
      6'd4:    begin d_size = 3'd2; d_load = 1'b1; end
      6'd15:   d_size = 3'd1;
      6'd16:   d_size = 3'd2;
      6'd17:   d_size = 3'd4;
      default: d_legal = 1'b0;
    endcase
    d_off = bus.addr[1:0];
    case (d_size)
      3'd1:    d_base = 4'h1;
      3'd2:    d_base = 4'h3;
      default: d_base = 4'hF;
    endcase
    d_mask  = {3'b000, d_base} << d_off;
    d_cross = (({1'b0, d_off} + d_size) > 3'd4);
`ifdef MISALIGN_SPLIT_EN
    d_misal = 1'b0;
`else
    d_misal = ((d_size == 3'd2) && d_off[0]) || ((d_size == 3'd4) && (d_off != 2'd0));
`endif
  end

  // Second beat carries the bytes above the word boundary; rdata0_q holds the first word.
  logic [5:0]  sh_lo;
  logic [5:0]  sh_hi;
  logic [31:0] r0;
  logic [31:0] raw;
  logic [31:0] ext;

  always_comb begin
    sh_lo = {1'b0, off_q, 3'b000};
    sh_hi = 6'd32 - sh_lo;
    r0    = (state == RSP1) ? rdata0_q : bus.mem_rdata;
    raw   = (r0 >> sh_lo) | ((state == RSP1) ? (bus.mem_rdata << sh_hi) : 32'h0);
    case (size_q)
      3'd1:    ext = sext_q ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
      3'd2:    ext = sext_q ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.rdata      <= 32'h0;
      bus.fault      <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_be     <= 4'h0;
      bus.mem_wdata  <= 32'h0;
      off_q          <= 2'd0;
      size_q         <= 3'd0;
      load_q         <= 1'b0;
      sext_q         <= 1'b0;
      cross_q        <= 1'b0;
      mask_hi_q      <= 3'd0;
      wdata_q        <= 32'h0;
      rdata0_q       <= 32'h0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            off_q         <= d_off;
            size_q        <= d_size;
            load_q        <= d_load;
            sext_q        <= d_sext;
            cross_q       <= d_cross;
            mask_hi_q     <= d_mask[6:4];
            wdata_q       <= bus.wdata;
            if (!d_legal || d_misal) begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
              bus.fault      <= 1'b1;
              bus.rdata      <= 32'h0;
            end else begin
              state         <= REQ0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= !d_load;
              bus.mem_addr  <= {bus.addr[ADDR_W-1:2], 2'b00};
              bus.mem_be    <= d_mask[3:0];
              bus.mem_wdata <= bus.wdata << {d_off, 3'b000};
            end
          end
        end
        REQ0: if (bus.mem_gnt) begin
          bus.mem_req <= 1'b0;
          state       <= RSP0;
        end
        RSP0: if (bus.mem_rvalid) begin
          if (cross_q) begin
            rdata0_q      <= bus.mem_rdata;
            state         <= REQ1;
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= bus.mem_addr + ADDR_W'(4);
            bus.mem_be    <= {1'b0, mask_hi_q};
            bus.mem_wdata <= wdata_q >> sh_hi;
          end else begin
            state          <= DONE;
            bus.resp_valid <= 1'b1;
            bus.fault      <= 1'b0;
            bus.rdata      <= load_q ? ext : 32'h0;
          end
        end
        REQ1: if (bus.mem_gnt) begin
          bus.mem_req <= 1'b0;
          state       <= RSP1;
        end
        RSP1: if (bus.mem_rvalid) begin
          state          <= DONE;
          bus.resp_valid <= 1'b1;
          bus.fault      <= 1'b0;
          bus.rdata      <= load_q ? ext : 32'h0;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a 32-bit-address instance with a word memory model and an
// 8-bit-address instance for address wrap; expectations adapt to MISALIGN_SPLIT_EN.
module tb_lsu_mem_ctrl;
  localparam logic [5:0] OP_LB = 6'd0, OP_LH = 6'd1, OP_LW = 6'd2, OP_LBU = 6'd3, OP_LHU = 6'd4;
  localparam logic [5:0] OP_SB = 6'd15, OP_SH = 6'd16, OP_SW = 6'd17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();
  lsu_mem_ctrl_if #(.ADDR_W(8))  bus8 ();
  lsu_mem_ctrl #(.ADDR_W(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  lsu_mem_ctrl #(.ADDR_W(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] memw [logic [31:0]];
  logic        gnt_en = 1'b1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] b_addr [$];
  logic [3:0]  b_be [$];
  logic [31:0] b_wd [$];
  logic        b_we [$];
  logic        pend8 = 1'b0;
  logic [7:0]  b8_addr [$];
  logic [3:0]  b8_be [$];
  logic [31:0] b8_wd [$];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return memw.exists(a) ? memw[a] : 32'h0;
  endfunction

  // Memory model: grant in the cycle mem_req is seen (when enabled), read data one cycle later.
  always @(negedge clk) begin
    bus.mem_rvalid = pend;
    bus.mem_rdata  = pend ? rd_word(pend_addr) : 32'h0;
    pend = 1'b0;
    if (bus.mem_req && gnt_en) begin
      bus.mem_gnt = 1'b1;
      b_addr.push_back(bus.mem_addr); b_be.push_back(bus.mem_be);
      b_wd.push_back(bus.mem_wdata);  b_we.push_back(bus.mem_we);
      pend = 1'b1;
      pend_addr = bus.mem_addr;
    end else begin
      bus.mem_gnt = 1'b0;
    end
  end

  always @(negedge clk) begin
    bus8.mem_rvalid = pend8;
    bus8.mem_rdata  = 32'h0;
    pend8 = 1'b0;
    if (bus8.mem_req) begin
      bus8.mem_gnt = 1'b1;
      b8_addr.push_back(bus8.mem_addr); b8_be.push_back(bus8.mem_be); b8_wd.push_back(bus8.mem_wdata);
      pend8 = 1'b1;
    end else begin
      bus8.mem_gnt = 1'b0;
    end
  end

  // Issue one request and wait (bounded) for its response; lat counts cycles after the accept cycle.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic flt);
    b_addr.delete(); b_be.delete(); b_wd.delete(); b_we.delete();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.op = op; bus.addr = addr; bus.wdata = wd;
    for (int i = 0; i < 10 && !bus.req_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 99; rd = 32'hx; flt = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      if (bus.resp_valid) begin
        lat = i; rd = bus.rdata; flt = bus.fault;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    vectors++;
    if ({bus.rdata, bus.fault, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 102'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdata=%h fault=%b we=%b be=%h addr=%h wdata=%h want all zero",
               bus.rdata, bus.fault, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_ext();
    int lat; logic [31:0] rd; logic flt;
    memw[32'h80] = 32'h000000F0;
    memw[32'h84] = 32'h80017FFF;
    issue(OP_LB, 32'h81, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL lb_81_rdata: got %h want 00000000", rd); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL lb_81_latency: got %0d want 3", lat); end
    vectors++; if (flt !== 1'b0) begin miscompares++; $display("FAIL lb_81_fault: got %b want 0", flt); end
    vectors++;
    if (b_addr.size() !== 1 || b_addr[0] !== 32'h80 || b_be[0] !== 4'b0010 || b_we[0] !== 1'b0) begin
      miscompares++; $display("FAIL lb_81_beat: got n=%0d addr=%h be=%b we=%b want 1 beat 00000080 0010 0",
                              b_addr.size(), b_addr[0], b_be[0], b_we[0]);
    end
    issue(OP_LB, 32'h80, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'hFFFFFFF0) begin miscompares++; $display("FAIL lb_80_rdata: got %h want fffffff0", rd); end
    issue(OP_LBU, 32'h80, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'h000000F0) begin miscompares++; $display("FAIL lbu_80_rdata: got %h want 000000f0", rd); end
    issue(OP_LH, 32'h86, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh_86_rdata: got %h want ffff8001", rd); end
    issue(OP_LHU, 32'h86, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'h00008001) begin miscompares++; $display("FAIL lhu_86_rdata: got %h want 00008001", rd); end
    issue(OP_LH, 32'h84, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'h00007FFF) begin miscompares++; $display("FAIL lh_84_rdata: got %h want 00007fff", rd); end
    issue(OP_LW, 32'h84, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'h80017FFF) begin miscompares++; $display("FAIL lw_84_rdata: got %h want 80017fff", rd); end
  endtask

  task automatic test_store();
    int lat; logic [31:0] rd; logic flt;
    issue(OP_SH, 32'h102, 32'h1234ABCD, lat, rd, flt);
    vectors++;
    if (b_addr.size() !== 1 || b_addr[0] !== 32'h100 || b_be[0] !== 4'b1100 || b_wd[0] !== 32'hABCD0000 || b_we[0] !== 1'b1) begin
      miscompares++; $display("FAIL sh_102_beat: got n=%0d addr=%h be=%b wd=%h we=%b want 1 beat 00000100 1100 abcd0000 1",
                              b_addr.size(), b_addr[0], b_be[0], b_wd[0], b_we[0]);
    end
    vectors++; if ({rd, flt} !== 33'h0) begin miscompares++; $display("FAIL sh_102_resp: got rdata=%h fault=%b want 0 0", rd, flt); end
    issue(OP_SB, 32'h103, 32'h0000005A, lat, rd, flt);
    vectors++;
    if (b_be[0] !== 4'b1000 || b_wd[0] !== 32'h5A000000) begin
      miscompares++; $display("FAIL sb_103_beat: got be=%b wd=%h want 1000 5a000000", b_be[0], b_wd[0]);
    end
    issue(OP_SW, 32'h108, 32'hDEADBEEF, lat, rd, flt);
    vectors++;
    if (b_addr[0] !== 32'h108 || b_be[0] !== 4'b1111 || b_wd[0] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL sw_108_beat: got addr=%h be=%b wd=%h want 00000108 1111 deadbeef", b_addr[0], b_be[0], b_wd[0]);
    end
  endtask

  task automatic test_illegal_op();
    int lat; logic [31:0] rd; logic flt;
    issue(6'd5, 32'h80, 32'h0, lat, rd, flt);
    vectors++;
    if (lat !== 1 || flt !== 1'b1 || rd !== 32'h0 || b_addr.size() !== 0) begin
      miscompares++; $display("FAIL illegal_op5: got lat=%0d fault=%b rdata=%h beats=%0d want 1 1 0 0", lat, flt, rd, b_addr.size());
    end
    issue(6'd63, 32'h80, 32'h0, lat, rd, flt);
    vectors++; if (lat !== 1 || flt !== 1'b1) begin miscompares++; $display("FAIL illegal_op63: got lat=%0d fault=%b want 1 1", lat, flt); end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic flt;
    memw[32'h100] = 32'hAABBCCDD;
    memw[32'h104] = 32'h11223344;
`ifdef MISALIGN_SPLIT_EN
    issue(OP_LW, 32'h103, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'h223344AA || flt !== 1'b0) begin miscompares++; $display("FAIL lw_103_split_rdata: got %h fault=%b want 223344aa 0", rd, flt); end
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL lw_103_split_latency: got %0d want 5", lat); end
    vectors++;
    if (b_addr.size() !== 2 || b_addr[0] !== 32'h100 || b_be[0] !== 4'b1000 || b_addr[1] !== 32'h104 || b_be[1] !== 4'b0111) begin
      miscompares++; $display("FAIL lw_103_split_beats: got n=%0d %h/%b %h/%b want 2 00000100/1000 00000104/0111",
                              b_addr.size(), b_addr[0], b_be[0], b_addr[1], b_be[1]);
    end
    issue(OP_LH, 32'h101, 32'h0, lat, rd, flt);
    vectors++;
    if (rd !== 32'hFFFFBBCC || b_addr.size() !== 1 || b_be[0] !== 4'b0110) begin
      miscompares++; $display("FAIL lh_101_inword: got rdata=%h beats=%0d be=%b want ffffbbcc 1 0110", rd, b_addr.size(), b_be[0]);
    end
    issue(OP_LH, 32'h103, 32'h0, lat, rd, flt);
    vectors++;
    if (rd !== 32'h000044AA || b_addr.size() !== 2 || b_be[1] !== 4'b0001) begin
      miscompares++; $display("FAIL lh_103_cross: got rdata=%h beats=%0d be1=%b want 000044aa 2 0001", rd, b_addr.size(), b_be[1]);
    end
`else
    issue(OP_LW, 32'h103, 32'h0, lat, rd, flt);
    vectors++;
    if (lat !== 1 || flt !== 1'b1 || rd !== 32'h0 || b_addr.size() !== 0) begin
      miscompares++; $display("FAIL lw_103_fault: got lat=%0d fault=%b rdata=%h beats=%0d want 1 1 0 0", lat, flt, rd, b_addr.size());
    end
    issue(OP_LH, 32'h101, 32'h0, lat, rd, flt);
    vectors++; if (lat !== 1 || flt !== 1'b1) begin miscompares++; $display("FAIL lh_101_fault: got lat=%0d fault=%b want 1 1", lat, flt); end
    issue(OP_SW, 32'h106, 32'h0, lat, rd, flt);
    vectors++; if (flt !== 1'b1 || b_addr.size() !== 0) begin miscompares++; $display("FAIL sw_106_fault: got fault=%b beats=%0d want 1 0", flt, b_addr.size()); end
    issue(OP_LHU, 32'h102, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'h0000AABB || flt !== 1'b0 || lat !== 3) begin miscompares++; $display("FAIL lhu_102_aligned: got %h fault=%b lat=%0d want 0000aabb 0 3", rd, flt, lat); end
`endif
  endtask

  task automatic test_addr_wrap();
    logic flt = 1'bx;
    b8_addr.delete(); b8_be.delete(); b8_wd.delete();
    @(negedge clk);
    bus8.req_valid = 1'b1; bus8.op = OP_SW; bus8.addr = 8'hFE; bus8.wdata = 32'h11223344;
    @(posedge clk); #1;
    bus8.req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.resp_valid) begin flt = bus8.fault; break; end
      @(posedge clk); #1;
    end
`ifdef MISALIGN_SPLIT_EN
    vectors++; if (flt !== 1'b0) begin miscompares++; $display("FAIL sw_fe_wrap_fault: got %b want 0", flt); end
    vectors++;
    if (b8_addr.size() !== 2 || b8_addr[0] !== 8'hFC || b8_be[0] !== 4'b1100 || b8_wd[0] !== 32'h33440000 ||
        b8_addr[1] !== 8'h00 || b8_be[1] !== 4'b0011 || b8_wd[1] !== 32'h00001122) begin
      miscompares++; $display("FAIL sw_fe_wrap_beats: got n=%0d %h/%b/%h %h/%b/%h want 2 fc/1100/33440000 00/0011/00001122",
                              b8_addr.size(), b8_addr[0], b8_be[0], b8_wd[0], b8_addr[1], b8_be[1], b8_wd[1]);
    end
`else
    vectors++; if (flt !== 1'b1 || b8_addr.size() !== 0) begin miscompares++; $display("FAIL sw_fe_fault: got fault=%b beats=%0d want 1 0", flt, b8_addr.size()); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_stall_reset();
    gnt_en = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.op = OP_LW; bus.addr = 32'h80; bus.wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h80, 32'h0}) begin
        miscompares++; $display("FAIL stall_hold_%0d: got req=%b we=%b be=%h addr=%h wd=%h want 1 0 f 00000080 0",
                                i, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
      end
      @(posedge clk); #1;
    end
    gnt_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL rsp0_reset: got req=%b ready=%b resp=%b want 0 1 0", bus.mem_req, bus.req_ready, bus.resp_valid);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        miscompares++; $display("FAIL late_rvalid_%0d: got resp=%b ready=%b want 0 1", i, bus.resp_valid, bus.req_ready);
      end
    end
    gnt_en = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.op = OP_LW; bus.addr = 32'h84;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0) begin
      miscompares++; $display("FAIL req0_reset: got req=%b addr=%h be=%h want 0 0 0", bus.mem_req, bus.mem_addr, bus.mem_be);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    gnt_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic flt;
    issue(OP_LBU, 32'h80, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'h000000F0) begin miscompares++; $display("FAIL b2b_first: got %h want 000000f0", rd); end
    issue(OP_LW, 32'h100, 32'h0, lat, rd, flt);
    vectors++; if (rd !== 32'hAABBCCDD || lat !== 3) begin miscompares++; $display("FAIL b2b_second: got %h lat=%0d want aabbccdd 3", rd, lat); end
    @(posedge clk); #1;
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL resp_pulse_width: got %b want 0", bus.resp_valid); end
    vectors++; if (bus.rdata !== 32'hAABBCCDD) begin miscompares++; $display("FAIL rdata_hold: got %h want aabbccdd", bus.rdata); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.op = 6'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
    bus8.req_valid = 1'b0; bus8.op = 6'd0; bus8.addr = 8'h0; bus8.wdata = 32'h0;
    test_reset();
    test_load_ext();
    test_store();
    test_illegal_op();
    test_misalign();
    test_addr_wrap();
    test_stall_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
